// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-set path and the hour/minute/second counters.
package watch_pkg;

   localparam int unsigned CLK_HZ              = 100_000_000;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 10_000_000;

   typedef enum logic [1:0] {
      RUN,
      SET_HOUR,
      SET_MIN,
      SET_SEC
   } watch_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchronizer, counting debouncer and press strobe on
// an accepted rising level.
module btn_debounce
   import watch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync0_d = raw;
      sync1_d = sync0_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // Any return to the accepted level restarts the stability count.
      if (sync1_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync1_q;
            press_d = sync1_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync0_q <= sync0_d;
         sync1_q <= sync1_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// RUN/SET controller for the watch time-set path: conditions the three buttons,
// selects the field being set and issues increment strobes with hold-to-repeat.
module watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_next,
   input  logic btn_inc,
   output logic mode,
   output logic change_hour,
   output logic change_minute,
   output logic change_second,
   output logic valid_response
);

   localparam int unsigned     REP_W      = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic mode_press, next_press, inc_press;
   logic mode_level, next_level, inc_level;
   logic unused_levels;

   watch_state_e     state_q, state_d;
   logic             inc_take;
   logic             rep_hold, rep_fire;
   logic             rep_active_q, rep_active_d;
   logic             rep_first_q,  rep_first_d;
   logic [REP_W-1:0] rep_cnt_q,    rep_cnt_d;

   logic mode_q,  mode_d;
   logic hour_q,  hour_d;
   logic min_q,   min_d;
   logic sec_q,   sec_d;
   logic valid_q, valid_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level), .press(mode_press)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk(clk), .rst(rst), .raw(btn_next), .level(next_level), .press(next_press)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk(clk), .rst(rst), .raw(btn_inc), .level(inc_level), .press(inc_press)
   );

   assign unused_levels = mode_level ^ next_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         rep_active_q <= 1'b0;
         rep_first_q  <= 1'b0;
         rep_cnt_q    <= '0;
         mode_q       <= 1'b0;
         hour_q       <= 1'b0;
         min_q        <= 1'b0;
         sec_q        <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rep_active_q <= rep_active_d;
         rep_first_q  <= rep_first_d;
         rep_cnt_q    <= rep_cnt_d;
         mode_q       <= mode_d;
         hour_q       <= hour_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         valid_q      <= valid_d;
      end
   end

   // Priority mode > next > inc; a losing inc press is dropped.
   always_comb begin
      state_d  = state_q;
      inc_take = 1'b0;
      if (mode_press) begin
         state_d = (state_q == RUN) ? SET_HOUR : RUN;
      end else if (next_press) begin
         case (state_q)
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            SET_SEC:  state_d = SET_HOUR;
            default:  state_d = state_q;
         endcase
      end else if (inc_press && (state_q != RUN)) begin
         inc_take = 1'b1;
      end
   end

   // Repeat timer runs from the accepted press; first interval REPEAT_DELAY, then REPEAT_PERIOD.
   always_comb begin
      rep_hold     = (state_d == state_q) && (state_q != RUN) && inc_level;
      rep_fire     = 1'b0;
      rep_active_d = 1'b0;
      rep_first_d  = rep_first_q;
      rep_cnt_d    = '0;
      if (inc_take) begin
         rep_active_d = 1'b1;
         rep_first_d  = 1'b1;
      end else if (rep_active_q && rep_hold) begin
         rep_active_d = 1'b1;
         if (rep_cnt_q == (rep_first_q ? DELAY_LAST : PERIOD_LAST)) begin
            rep_fire    = 1'b1;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
         end
      end
   end

   // Decoding the next state keeps outputs in step with the state register.
   always_comb begin
      mode_d  = (state_d != RUN);
      hour_d  = (state_d == SET_HOUR);
      min_d   = (state_d == SET_MIN);
      sec_d   = (state_d == SET_SEC);
      valid_d = inc_take | rep_fire;
   end

   assign mode           = mode_q;
   assign change_hour    = hour_q;
   assign change_minute  = min_q;
   assign change_second  = sec_q;
   assign valid_response = valid_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with short debounce and repeat timing.
module tb_watch_set_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic btn_mode, btn_next, btn_inc;
   logic mode, change_hour, change_minute, change_second, valid_response;

   int checks = 0;
   int errors = 0;

   watch_set_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_mode(btn_mode),
      .btn_next(btn_next),
      .btn_inc(btn_inc),
      .mode(mode),
      .change_hour(change_hour),
      .change_minute(change_minute),
      .change_second(change_second),
      .valid_response(valid_response)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] outs();
      return {mode, change_hour, change_minute, change_second};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int unsigned which, input logic v);
      case (which)
         0:       btn_mode = v;
         1:       btn_next = v;
         default: btn_inc  = v;
      endcase
   endtask

   // Clean press held through the response edge, then a settled release.
   task automatic hit(input int unsigned which);
      set_btn(which, 1'b1);
      repeat (7) step();
      set_btn(which, 1'b0);
      repeat (8) step();
   endtask

   task automatic test_reset();
      int busy;
      busy = 0;
      rst = 1'b1;
      btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      repeat (3) step();
      checks++;
      if ({outs(), valid_response} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {outs(), valid_response});
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if ({outs(), valid_response} !== 5'b00000) busy++;
      end
      checks++;
      if (busy != 0) begin
         errors++;
         $display("FAIL idle_quiet: %0d active cycles, expected 0", busy);
      end
   endtask

   task automatic test_mode_next();
      logic [3:0] exp_seq [3];
      exp_seq = '{4'b1010, 4'b1001, 4'b1100};
      btn_mode = 1'b1;
      repeat (6) step();
      checks++;
      if (outs() !== 4'b0000) begin
         errors++;
         $display("FAIL mode_edge5: got %b expected 0000", outs());
      end
      step();
      checks++;
      if (outs() !== 4'b1100) begin
         errors++;
         $display("FAIL mode_edge6: got %b expected 1100", outs());
      end
      btn_mode = 1'b0;
      repeat (8) step();
      for (int i = 0; i < 3; i++) begin
         hit(1);
         checks++;
         if (outs() !== exp_seq[i]) begin
            errors++;
            $display("FAIL next_%0d: got %b expected %b", i, outs(), exp_seq[i]);
         end
      end
   endtask

   task automatic test_bounce();
      logic bp [5];
      int pulses, first;
      bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      hit(1);
      checks++;
      if (outs() !== 4'b1010) begin
         errors++;
         $display("FAIL bounce_setup: got %b expected 1010", outs());
      end
      for (int pass = 0; pass < 2; pass++) begin
         pulses = 0;
         first  = -1;
         for (int i = 0; i < 5; i++) begin
            btn_inc = bp[i];
            step();
            if (valid_response) pulses++;
         end
         btn_inc = 1'b1;
         for (int i = 0; i < 14; i++) begin
            step();
            if (valid_response) begin
               if (first < 0) first = i;
               pulses++;
            end
         end
         btn_inc = 1'b0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (valid_response) pulses++;
         end
         if (pass == 0) begin
            checks++;
            if (pulses != 1 || first != 6) begin
               errors++;
               $display("FAIL bounce_set: pulses %0d at edge %0d, expected 1 at edge 6", pulses, first);
            end
            hit(0);
            checks++;
            if (outs() !== 4'b0000) begin
               errors++;
               $display("FAIL mode_to_run: got %b expected 0000", outs());
            end
         end else begin
            checks++;
            if (pulses != 0 || outs() !== 4'b0000) begin
               errors++;
               $display("FAIL bounce_run: pulses %0d outs %b, expected 0 and 0000", pulses, outs());
            end
         end
      end
      hit(1);
      checks++;
      if (outs() !== 4'b0000) begin
         errors++;
         $display("FAIL next_in_run: got %b expected 0000", outs());
      end
   endtask

   task automatic test_auto_repeat();
      int times [6];
      int got [8];
      int n, dbl;
      logic prev;
      times = '{6, 26, 31, 36, 41, 46};
      n = 0; dbl = 0; prev = 1'b0;
      hit(0);
      hit(1);
      hit(1);
      checks++;
      if (outs() !== 4'b1001) begin
         errors++;
         $display("FAIL repeat_setup: got %b expected 1001", outs());
      end
      btn_inc = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (i == 43) btn_inc = 1'b0;
         step();
         if (valid_response) begin
            if (prev) dbl++;
            if (n < 8) got[n] = i;
            n++;
         end
         prev = valid_response;
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL repeat_count: got %0d pulses expected 6", n);
      end
      for (int k = 0; k < 6; k++) begin
         if (k < n) begin
            checks++;
            if (got[k] != times[k]) begin
               errors++;
               $display("FAIL repeat_time_%0d: edge %0d expected %0d", k, got[k], times[k]);
            end
         end
      end
      checks++;
      if (dbl != 0 || outs() !== 4'b1001) begin
         errors++;
         $display("FAIL repeat_hold: double %0d outs %b, expected 0 and 1001", dbl, outs());
      end
   endtask

   task automatic test_same_cycle();
      int pulses;
      hit(1);
      checks++;
      if (outs() !== 4'b1100) begin
         errors++;
         $display("FAIL same_setup: got %b expected 1100", outs());
      end
      pulses = 0;
      btn_mode = 1'b1; btn_inc = 1'b1;
      for (int i = 0; i < 22; i++) begin
         if (i == 14) begin btn_mode = 1'b0; btn_inc = 1'b0; end
         step();
         if (valid_response) pulses++;
      end
      checks++;
      if (pulses != 0 || outs() !== 4'b0000) begin
         errors++;
         $display("FAIL mode_beats_inc: pulses %0d outs %b, expected 0 and 0000", pulses, outs());
      end
      hit(0);
      pulses = 0;
      btn_next = 1'b1; btn_inc = 1'b1;
      for (int i = 0; i < 22; i++) begin
         if (i == 14) begin btn_next = 1'b0; btn_inc = 1'b0; end
         step();
         if (valid_response) pulses++;
      end
      checks++;
      if (pulses != 0 || outs() !== 4'b1010) begin
         errors++;
         $display("FAIL next_beats_inc: pulses %0d outs %b, expected 0 and 1010", pulses, outs());
      end
   endtask

   task automatic test_reset_repeat();
      int pulses, busy;
      pulses = 0; busy = 0;
      btn_inc = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (valid_response) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL prereset_press: got %0d pulses expected 1", pulses);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({outs(), valid_response} !== 5'b00000) begin
         errors++;
         $display("FAIL midrepeat_reset: got %b expected 00000", {outs(), valid_response});
      end
      for (int i = 0; i < 30; i++) begin
         step();
         if ({outs(), valid_response} !== 5'b00000) busy++;
      end
      btn_inc = 1'b0;
      repeat (8) step();
      checks++;
      if (busy != 0) begin
         errors++;
         $display("FAIL postreset_run: %0d active cycles, expected 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_mode_next();
      test_bounce();
      test_auto_repeat();
      test_same_cycle();
      test_reset_repeat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Front-end controller for the digital watch's time-set path. It conditions three raw push-buttons (mode, next, increment), runs the RUN/SET state machine, and drives the set-mode control signals consumed directly by the hour, minute and second counters: `mode`, one-hot `change_hour`/`change_minute`/`change_second`, and single-cycle `valid_response` increment strobes with hold-to-repeat.

## Interface
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable cycles before a button level is accepted (10 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50_000_000 — cycles increment must stay held after its press strobe before the first auto-repeat.
- REPEAT_PERIOD, 10_000_000 — cycles between subsequent auto-repeat strobes.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- btn_mode  in  1  raw asynchronous mode button, active-high.
- btn_next  in  1  raw asynchronous field-select button, active-high.
- btn_inc  in  1  raw asynchronous increment button, active-high.
- mode  out  1  high in any SET state; counters hold and accept only strobed increments.
- change_hour  out  1  high only in SET_HOUR.
- change_minute  out  1  high only in SET_MIN.
- change_second  out  1  high only in SET_SEC.
- valid_response  out  1  one-cycle increment strobe; only ever high while `mode` is high.

## Operation
- Each button path: 2-flop synchronizer → debouncer → rising-edge press strobe.
  - Debouncer: `cnt` increments while synchronized value ≠ accepted level and clears when they match.
  - When `cnt == DEBOUNCE_CYCLES-1` and the values still differ, the accepted level takes the synchronized value, `cnt` clears, and a one-cycle `press` strobe is registered if the new level is 1.
  - Releases are debounced identically but produce no strobe.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - RUN + mode press → SET_HOUR.
  - Any SET state + mode press → RUN.
  - Next press: SET_HOUR → SET_MIN → SET_SEC → SET_HOUR.
  - Next press in RUN is ignored.
- Same-cycle priority: mode > next > inc. A suppressed inc press is discarded, not queued.
- Increment, in SET states only:
  - An inc press registers `valid_response`=1 for exactly one cycle.
  - Inc presses in RUN are ignored.
- Auto-repeat:
  - `rep_cnt` starts at the press strobe. While the debounced inc level stays 1 and the state is unchanged, the first repeat strobe occurs REPEAT_DELAY cycles after the press strobe, then one every REPEAT_PERIOD cycles.
  - `rep_cnt` clears on inc release, any state change, or reset.
- Outputs are registered decodes of the state. `change_*` are one-hot in SET states and all 0 in RUN.
- Counter widths: debounce counters $clog2(DEBOUNCE_CYCLES); `rep_cnt` $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). No wrap is reachable.

## Timing
- Reset values:
  - State RUN.
  - `mode`, `change_*`, `valid_response` all 0.
  - Synchronizers, accepted levels, debounce counters, `rep_cnt` and press strobes all 0.
- Reset asserted mid-debounce or mid-repeat aborts the operation. A button still held when reset releases must be re-debounced from 0 and does generate a press.
- Latency: count the edge that first samples a clean raw high as edge 0.
  - Press strobe is registered at edge DEBOUNCE_CYCLES+1.
  - FSM outputs / `valid_response` change at edge DEBOUNCE_CYCLES+2.
- Bounce: any raw glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no level change and no strobe.
- `valid_response` never stays high for 2 consecutive cycles. It is never high in the same cycle that `mode` falls, or in the cycle `change_*` changes.

## Structure
- Shared package `watch_pkg` holds:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC);
  - CLK_HZ = 100_000_000;
  - default debounce and repeat constants, shared with the counter blocks.
- Sub-module `btn_debounce`, parameter DEBOUNCE_CYCLES, ports clk, rst, raw, level, press. It contains the synchronizer, the debouncer and edge detect, and is instantiated three times.
- The FSM and repeat timer live in `watch_set_ctrl`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset, then idle for 50 cycles → state RUN, all outputs 0, no strobes.
- `btn_mode` held clean from edge 0 → `mode`=1 and `change_hour`=1 at edge 6. Then `btn_next` press ×3 → SET_MIN, SET_SEC, SET_HOUR in order, always exactly one `change_*` high.
- `btn_inc` bounced 1,0,1,1,0 then held 1 in SET_MIN → exactly one `valid_response` pulse at 4 stable cycles + latency. In RUN, the same stimulus → no pulse.
- `btn_inc` held for 40 cycles after its press strobe in SET_SEC → pulses at press+0, +20, +25, +30, +35, +40. Release → no further pulses.
- `btn_mode` and `btn_inc` debounced on the same edge in SET_HOUR → state RUN, `valid_response` stays 0. Same case with `btn_next` and `btn_inc` → SET_MIN, no pulse.
- `rst` asserted for 1 cycle during auto-repeat with `btn_inc` still held → outputs 0, state RUN. New debounce begins and the press in RUN yields no pulse.
